// File: rtl/gpio_in_cond_if.sv
// Pad-side / GPIO-block-side signal bundle for the input conditioner.
// Latency: n/a (wires only). Backpressure: none, all signals are levels or single-cycle pulses.
// slave = conditioner, master = whatever drives the pads and irq controls.
interface gpio_in_cond_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] i_pad;
  logic [WIDTH-1:0] o_gpio_in;
  logic [WIDTH-1:0] o_rise;
  logic [WIDTH-1:0] o_fall;
  logic [WIDTH-1:0] i_irq_en;
  logic [WIDTH-1:0] i_irq_clr;
  logic [WIDTH-1:0] o_irq_pend;
  logic             o_irq;

  modport master (
    output i_pad, i_irq_en, i_irq_clr,
    input  o_gpio_in, o_rise, o_fall, o_irq_pend, o_irq
  );

  modport slave (
    input  i_pad, i_irq_en, i_irq_clr,
    output o_gpio_in, o_rise, o_fall, o_irq_pend, o_irq
  );
endinterface

// File: rtl/gpio_in_cond.sv
// Pad input conditioner: synchroniser + per-bit debounce + rise/fall pulses; edge-irq latch under GPIO_IN_EDGE_IRQ_EN.
// Latency: SYNC_STAGES+DEBOUNCE_CYCLES edges from pad change to o_gpio_in/o_rise/o_fall (pend +1, irq +2).
// Backpressure: none; downstream samples every cycle, pulses are never held.
module gpio_in_cond #(
  parameter int WIDTH           = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic          i_wb_clk,
  input  logic          i_wb_rst_n,
  gpio_in_cond_if.slave bus
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync_r [SYNC_STAGES];
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] rise_r;
  logic [WIDTH-1:0] fall_r;
  logic [CW-1:0]    cnt_r  [WIDTH];

  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_r[k] <= '0;
    end else begin
      sync_r[0] <= bus.i_pad;
      for (int k = 1; k < SYNC_STAGES; k++) sync_r[k] <= sync_r[k-1];
    end
  end

  assign s = sync_r[SYNC_STAGES-1];

  // Accept on the cycle the count has already seen DEBOUNCE_CYCLES-1 mismatches, so the
  // DEBOUNCE_CYCLES-th consecutive mismatching sample commits; the accept also clears cnt.
  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      q_r    <= '0;
      rise_r <= '0;
      fall_r <= '0;
      for (int i = 0; i < WIDTH; i++) cnt_r[i] <= '0;
    end else begin
      rise_r <= '0;
      fall_r <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        if (s[i] == q_r[i]) begin
          cnt_r[i] <= '0;
        end else if (cnt_r[i] == CNT_MAX) begin
          q_r[i]    <= s[i];
          cnt_r[i]  <= '0;
          rise_r[i] <= s[i];
          fall_r[i] <= ~s[i];
        end else begin
          cnt_r[i] <= cnt_r[i] + CW'(1);
        end
      end
    end
  end

  assign bus.o_gpio_in = q_r;
  assign bus.o_rise    = rise_r;
  assign bus.o_fall    = fall_r;

`ifdef GPIO_IN_EDGE_IRQ_EN
  logic [WIDTH-1:0] pend_r;
  logic             irq_r;

  // A new edge wins over a clear in the same cycle so no event is lost.
  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      pend_r <= '0;
      irq_r  <= 1'b0;
    end else begin
      pend_r <= (pend_r & ~bus.i_irq_clr) | ((rise_r | fall_r) & bus.i_irq_en);
      irq_r  <= |pend_r;
    end
  end

  assign bus.o_irq_pend = pend_r;
  assign bus.o_irq      = irq_r;
`else
  logic unused_irq_ok;
  assign unused_irq_ok  = &{1'b0, bus.i_irq_en, bus.i_irq_clr};
  assign bus.o_irq_pend = '0;
  assign bus.o_irq      = 1'b0;
`endif

endmodule

// File: tb/tb_gpio_in_cond.sv
// Directed table-driven bench for gpio_in_cond (WIDTH=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=16).
// Irq expectations follow GPIO_IN_EDGE_IRQ_EN as defined for this build.
module tb_gpio_in_cond;

`ifdef GPIO_IN_EDGE_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  gpio_in_cond_if #(.WIDTH(4)) bus ();

  gpio_in_cond #(
    .WIDTH           (4),
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (16)
  ) dut (
    .i_wb_clk   (clk),
    .i_wb_rst_n (rst_n),
    .bus        (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  pad;
    int unsigned cyc;
    logic [3:0]  gpio;
    logic [3:0]  rise;
    logic [3:0]  fall;
  } vec_t;

  vec_t vt [16];

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] g, input logic [3:0] r,
                         input logic [3:0] f);
    chk({tag, " gpio"}, bus.o_gpio_in, g);
    chk({tag, " rise"}, bus.o_rise, r);
    chk({tag, " fall"}, bus.o_fall, f);
  endtask

  logic [3:0] p1;
  logic [3:0] i1;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    p1 = IRQ_ON ? 4'b0001 : 4'b0000;
    i1 = IRQ_ON ? 4'b0001 : 4'b0000;

    vt[0]  = '{4'h0, 17, 4'hF, 4'h0, 4'h0};
    vt[1]  = '{4'h0,  1, 4'h0, 4'h0, 4'hF};
    vt[2]  = '{4'h0,  1, 4'h0, 4'h0, 4'h0};
    vt[3]  = '{4'h1, 15, 4'h0, 4'h0, 4'h0};  // 15-cycle glitch on bit0
    vt[4]  = '{4'h0, 20, 4'h0, 4'h0, 4'h0};
    vt[5]  = '{4'h4, 17, 4'h0, 4'h0, 4'h0};
    vt[6]  = '{4'h4,  1, 4'h4, 4'h4, 4'h0};
    vt[7]  = '{4'h4,  1, 4'h4, 4'h0, 4'h0};
    vt[8]  = '{4'h4, 10, 4'h4, 4'h0, 4'h0};
    vt[9]  = '{4'h0, 17, 4'h4, 4'h0, 4'h0};
    vt[10] = '{4'h0,  1, 4'h0, 4'h0, 4'h4};
    vt[11] = '{4'h0,  1, 4'h0, 4'h0, 4'h0};
    vt[12] = '{4'hA, 18, 4'hA, 4'hA, 4'h0};
    vt[13] = '{4'hA,  1, 4'hA, 4'h0, 4'h0};
    vt[14] = '{4'h5, 18, 4'h5, 4'h5, 4'hA};
    vt[15] = '{4'h5,  1, 4'h5, 4'h0, 4'h0};

    rst_n         = 1'b0;
    bus.i_pad     = 4'h0;
    bus.i_irq_en  = 4'h0;
    bus.i_irq_clr = 4'h0;

    // Reset held while pads toggle
    for (int k = 0; k < 6; k++) begin
      step(1);
      bus.i_pad = (k % 2 == 0) ? 4'hF : 4'h0;
    end
    step(1);
    chk_all("rst", 4'h0, 4'h0, 4'h0);
    chk("rst pend", bus.o_irq_pend, 4'h0);
    chk("rst irq", {3'b0, bus.o_irq}, 4'h0);

    bus.i_pad = 4'hF;
    rst_n     = 1'b1;
    step(17);
    chk_all("init e17", 4'h0, 4'h0, 4'h0);
    step(1);
    chk_all("init e18", 4'hF, 4'hF, 4'h0);
    step(1);
    chk_all("init e19", 4'hF, 4'h0, 4'h0);

    for (int v = 0; v < 16; v++) begin
      bus.i_pad = vt[v].pad;
      step(int'(vt[v].cyc));
      chk_all($sformatf("vec%0d", v), vt[v].gpio, vt[v].rise, vt[v].fall);
      chk($sformatf("vec%0d pend", v), bus.o_irq_pend, 4'h0);
    end

    // Bit1 toggling mid-count, then reset mid-debounce
    bus.i_pad = 4'h7;
    step(5);
    bus.i_pad = 4'h5;
    step(2);
    bus.i_pad = 4'h7;
    step(5);
    chk_all("toggle", 4'h5, 4'h0, 4'h0);
    rst_n = 1'b0;
    #1;
    chk_all("midrst", 4'h0, 4'h0, 4'h0);
    step(3);
    rst_n = 1'b1;
    step(17);
    chk_all("rerel e17", 4'h0, 4'h0, 4'h0);
    step(1);
    chk_all("rerel e18", 4'h7, 4'h7, 4'h0);
    step(1);
    chk_all("rerel e19", 4'h7, 4'h0, 4'h0);

    // Edges on bits 0 and 3 with only bit0 enabled
    bus.i_irq_en = 4'b0001;
    bus.i_pad    = 4'hE;
    step(18);
    chk_all("irq edge", 4'hE, 4'h8, 4'h1);
    chk("irq pend e18", bus.o_irq_pend, 4'h0);
    step(1);
    chk("irq pend e19", bus.o_irq_pend, p1);
    chk("irq irq e19", {3'b0, bus.o_irq}, 4'h0);
    step(1);
    chk("irq irq e20", {3'b0, bus.o_irq}, i1);

    bus.i_irq_clr = 4'b0001;
    step(1);
    chk("clr pend", bus.o_irq_pend, 4'h0);
    chk("clr irq lag", {3'b0, bus.o_irq}, i1);
    bus.i_irq_clr = 4'b0000;
    step(1);
    chk("clr irq", {3'b0, bus.o_irq}, 4'h0);

    // Clear coincident with a new edge: set wins
    bus.i_pad = 4'hF;
    step(18);
    chk_all("coin edge", 4'hF, 4'h1, 4'h0);
    bus.i_irq_clr = 4'b0001;
    step(1);
    chk("coin pend", bus.o_irq_pend, p1);
    bus.i_irq_clr = 4'b0000;
    step(1);
    chk("coin pend2", bus.o_irq_pend, p1);
    chk("coin irq", {3'b0, bus.o_irq}, i1);
    bus.i_irq_en = 4'b0000;
    step(2);
    chk("en off pend", bus.o_irq_pend, p1);
    chk_all("final", 4'hF, 4'h0, 4'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
